// File: rtl/neuron_pkg.sv
// Shared definitions for the perceptron trainer: FSM states, bipolar target
// codes and a saturating adder used by the weight/bias update.
package neuron_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CALC,
    S_UPDATE,
    S_EPOCH_END,
    S_DONE
  } state_t;

  localparam logic [1:0] T_POS = 2'b01;
  localparam logic [1:0] T_NEG = 2'b11;

  // Adds two signed values and clamps the sum to a signed range of 'width'
  // bits. Operands are 64 bits wide, so callers must keep width below 63.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 width);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    sum = a + b;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/perceptron_dp.sv
// Perceptron datapath: weight/bias registers, full-width MAC, three-level
// activation and saturating learning update.
module perceptron_dp
  import neuron_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int X_W    = 7,
  parameter int W_W    = 14,
  parameter int THETA  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    calc,
  input  logic                    update,
  input  logic [NUM_IN*X_W-1:0]   x_in,
  input  logic [1:0]              t_in,
  output logic                    mismatch,
  output logic [NUM_IN*W_W-1:0]   w_out,
  output logic [W_W-1:0]          b_out
);

  localparam int ACC_W = W_W + X_W + $clog2(NUM_IN + 1) + 1;
  localparam logic signed [ACC_W-1:0] THETA_A = ACC_W'(THETA);

  logic signed [X_W-1:0]   x_q [NUM_IN];
  logic signed [W_W-1:0]   w_q [NUM_IN];
  logic signed [W_W-1:0]   b_q;
  logic                    t_pos_q;
  logic signed [1:0]       y_q;
  logic signed [1:0]       y_d;
  logic signed [ACC_W-1:0] net;

  // ACC_W leaves headroom for NUM_IN full-scale products plus the bias.
  always_comb begin
    net = ACC_W'(b_q);
    for (int i = 0; i < NUM_IN; i++) begin
      net = net + ACC_W'(w_q[i]) * ACC_W'(x_q[i]);
    end
  end

  // NOTE: every variable written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    y_d = 2'sb00;
    if (net > THETA_A)       y_d = 2'sb01;
    else if (net < -THETA_A) y_d = 2'sb11;
  end

  assign mismatch = (y_q != (t_pos_q ? 2'sb01 : 2'sb11));

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the sample latches are reset along with the weights so nothing
      // downstream ever sees X, even though they are rewritten before use.
      for (int i = 0; i < NUM_IN; i++) begin
        x_q[i] <= '0;
        w_q[i] <= '0;
      end
      b_q     <= '0;
      t_pos_q <= 1'b0;
      y_q     <= '0;
    end else begin
      if (clear) begin
        for (int i = 0; i < NUM_IN; i++) w_q[i] <= '0;
        b_q <= '0;
      end else if (update && mismatch) begin
        for (int i = 0; i < NUM_IN; i++) begin
          w_q[i] <= W_W'(sat_add(64'(w_q[i]),
                                 t_pos_q ? 64'(x_q[i]) : -64'(x_q[i]), W_W));
        end
        b_q <= W_W'(sat_add(64'(b_q), t_pos_q ? 64'sd1 : -64'sd1, W_W));
      end
      if (load) begin
        for (int i = 0; i < NUM_IN; i++) x_q[i] <= x_in[i*X_W +: X_W];
        // Any code other than T_POS is a -1 target.
        t_pos_q <= (t_in == T_POS);
      end
      if (calc) y_q <= y_d;
    end
  end

  always_comb begin
    w_out = '0;
    for (int i = 0; i < NUM_IN; i++) w_out[i*W_W +: W_W] = w_q[i];
  end

  assign b_out = b_q;

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron trainer: epoch/sample sequencing, request/ready sample fetch and
// convergence detection around the perceptron_dp datapath.
module perceptron_trainer
  import neuron_pkg::*;
#(
  parameter int NUM_IN    = 2,
  parameter int X_W       = 7,
  parameter int W_W       = 14,
  parameter int CNT_W     = 32,
  parameter int THETA     = 0,
  parameter int MAX_EPOCH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        n_in,
  input  logic [NUM_IN*X_W-1:0]   x_in,
  input  logic [1:0]              t_in,
  input  logic                    data_ready,
  output logic                    request,
  output logic [CNT_W-1:0]        sample_idx,
  output logic [15:0]             epoch_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    converged,
  output logic [NUM_IN*W_W-1:0]   w_out,
  output logic [W_W-1:0]          b_out
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [15:0]      epoch_q, epoch_d;
  logic             err_q, err_d;
  logic             conv_q, conv_d;
  logic             dp_clear, dp_load, dp_calc, dp_update, mismatch;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      epoch_q <= '0;
      err_q   <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      epoch_q <= epoch_d;
      err_q   <= err_d;
      conv_q  <= conv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    epoch_d   = epoch_q;
    err_d     = err_q;
    conv_d    = conv_q;
    dp_clear  = 1'b0;
    dp_load   = 1'b0;
    dp_calc   = 1'b0;
    dp_update = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          n_d      = n_in;
          dp_clear = 1'b1;
          epoch_d  = 16'd1;
          idx_d    = '0;
          err_d    = 1'b0;
          if (n_in == '0) begin
            state_d = S_DONE;
            conv_d  = 1'b1;
          end else begin
            state_d = S_REQ;
            conv_d  = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (data_ready) begin
          dp_load = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        dp_calc = 1'b1;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        dp_update = 1'b1;
        if (mismatch) err_d = 1'b1;
        idx_d   = idx_q + CNT_W'(1);
        state_d = (idx_q + CNT_W'(1) == n_q) ? S_EPOCH_END : S_REQ;
      end
      S_EPOCH_END: begin
        if (!err_q) begin
          state_d = S_DONE;
          conv_d  = 1'b1;
        end else if (epoch_q == 16'(MAX_EPOCH)) begin
          state_d = S_DONE;
          conv_d  = 1'b0;
        end else begin
          epoch_d = epoch_q + 16'd1;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign request    = (state_q == S_REQ);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign converged  = conv_q;
  assign sample_idx = idx_q;
  assign epoch_cnt  = epoch_q;

  perceptron_dp #(
    .NUM_IN (NUM_IN),
    .X_W    (X_W),
    .W_W    (W_W),
    .THETA  (THETA)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .clear    (dp_clear),
    .load     (dp_load),
    .calc     (dp_calc),
    .update   (dp_update),
    .x_in     (x_in),
    .t_in     (t_in),
    .mismatch (mismatch),
    .w_out    (w_out),
    .b_out    (b_out)
  );

endmodule
